// File: rtl/ln_out_packer.sv
`default_nettype none
// ============================================================================
//  Module      : ln_out_packer
//  Description : Layer-norm output stream packer. Applies a rounding arithmetic
//                right shift to each signed D_W_ACC-bit sample, narrows it to
//                D_W bits and packs X_W/D_W lanes little-endian into X_W-bit
//                words. Rows never share a word (partial words are flushed at
//                end of row). Matrix-level tlast is regenerated from DIM1 x DIM2
//                counters; a disagreeing upstream tlast sets a sticky flag.
//                Optional macro LN_OUT_SAT_EN: saturate instead of wrap when
//                narrowing.
//  Revision    : 1.0 - initial release
// ============================================================================
module ln_out_packer #(
    parameter int D_W_ACC      = 32,
    parameter int D_W          = 8,
    parameter int X_W          = 32,
    parameter int SHIFT        = 0,
    parameter int MATRIXSIZE_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [D_W_ACC-1:0]      ln_tdata,
    input  logic                    ln_tlast,
    input  logic                    ln_tvalid,
    output logic                    ln_tready,
    output logic [X_W-1:0]          out_tdata,
    output logic [X_W/8-1:0]        out_tkeep,
    output logic                    out_tlast,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    input  logic [MATRIXSIZE_W-1:0] DIM1,
    input  logic [MATRIXSIZE_W-1:0] DIM2,
    output logic                    tlast_err
);

    localparam int c_P     = X_W / D_W;
    localparam int c_KW    = (c_P > 1) ? $clog2(c_P) : 1;
    localparam int c_BYTES = X_W / 8;

    // Half-LSB rounding offset; zero when no shift is applied.
    localparam logic signed [D_W_ACC:0] c_ROUND =
        (SHIFT == 0) ? '0 : ((D_W_ACC+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0));

    localparam logic [c_KW-1:0]         c_K_LAST = c_KW'(c_P - 1);
    localparam logic [c_KW-1:0]         c_K_ONE  = c_KW'(1);
    localparam logic [MATRIXSIZE_W-1:0] c_M_ONE  = MATRIXSIZE_W'(1);

    logic [c_KW-1:0]         r_k;
    logic [MATRIXSIZE_W-1:0] r_row;
    logic [MATRIXSIZE_W-1:0] r_col;
    logic [X_W-1:0]          r_pack;
    logic [X_W-1:0]          r_out_tdata;
    logic [c_BYTES-1:0]      r_out_tkeep;
    logic                    r_out_tlast;
    logic                    r_out_tvalid;
    logic                    r_tlast_err;

    logic                    w_accept;
    logic                    w_row_end;
    logic                    w_mat_end;
    logic                    w_complete;
    logic signed [D_W_ACC:0] w_ext;
    logic signed [D_W_ACC:0] w_sum;
    logic signed [D_W_ACC:0] w_shr;
    logic [D_W-1:0]          w_narrow;
    logic [X_W-1:0]          w_pack_next;
    logic [c_BYTES-1:0]      w_keep;

    // Ready depends only on registered output state and the sink's ready.
    assign ln_tready  = out_tready | ~r_out_tvalid;
    assign w_accept   = ln_tvalid & ln_tready;
    assign w_row_end  = (r_col == DIM2 - c_M_ONE);
    assign w_mat_end  = w_row_end & (r_row == DIM1 - c_M_ONE);
    assign w_complete = w_accept & ((r_k == c_K_LAST) | w_row_end);

    // One extra bit of headroom so the rounding add cannot overflow.
    assign w_ext = $signed({ln_tdata[D_W_ACC-1], ln_tdata});
    assign w_sum = w_ext + c_ROUND;
    assign w_shr = w_sum >>> SHIFT;

`ifdef LN_OUT_SAT_EN
    localparam logic signed [D_W_ACC:0] c_SAT_MAX =
        {{(D_W_ACC + 2 - D_W){1'b0}}, {(D_W - 1){1'b1}}};
    localparam logic signed [D_W_ACC:0] c_SAT_MIN = ~c_SAT_MAX;

    // Clamp the shifted value into the signed D_W-bit range.
    always_comb begin
        w_narrow = w_shr[D_W-1:0];
        if (w_shr > c_SAT_MAX) begin
            w_narrow = c_SAT_MAX[D_W-1:0];
        end else if (w_shr < c_SAT_MIN) begin
            w_narrow = c_SAT_MIN[D_W-1:0];
        end
    end
`else
    // Two's-complement wrap: keep only the low D_W bits.
    assign w_narrow = w_shr[D_W-1:0];
`endif

    // Pack register with the current sample dropped into lane k.
    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[int'(r_k)*D_W +: D_W] = w_narrow;
    end

    // Byte enables covering lanes 0..k of the word being completed.
    always_comb begin
        w_keep = '0;
        for (int b = 0; b < c_BYTES; b++) begin
            if (b * 8 < (int'(r_k) + 1) * D_W) begin
                w_keep[b] = 1'b1;
            end
        end
    end

    // Lane index, pack register and row/column position advance per accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_pack <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_k    <= '0;
                r_pack <= '0;
            end else begin
                r_k    <= r_k + c_K_ONE;
                r_pack <= w_pack_next;
            end
            if (w_row_end) begin
                r_col <= '0;
                r_row <= w_mat_end ? '0 : r_row + c_M_ONE;
            end else begin
                r_col <= r_col + c_M_ONE;
            end
        end
    end

    // Output register: reload on completion (even during a handshake), else drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_tdata  <= '0;
            r_out_tkeep  <= '0;
            r_out_tlast  <= 1'b0;
            r_out_tvalid <= 1'b0;
        end else if (w_complete) begin
            r_out_tdata  <= w_pack_next;
            r_out_tkeep  <= w_keep;
            r_out_tlast  <= w_mat_end;
            r_out_tvalid <= 1'b1;
        end else if (out_tready) begin
            r_out_tvalid <= 1'b0;
        end
    end

    // Sticky flag for an upstream tlast that disagrees with the counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tlast_err <= 1'b0;
        end else if (w_accept && (ln_tlast != w_mat_end)) begin
            r_tlast_err <= 1'b1;
        end
    end

    assign out_tdata  = r_out_tdata;
    assign out_tkeep  = r_out_tkeep;
    assign out_tlast  = r_out_tlast;
    assign out_tvalid = r_out_tvalid;
    assign tlast_err  = r_tlast_err;

endmodule
`default_nettype wire

// File: tb/tb_ln_out_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ln_out_packer
//  Description : Directed self-checking bench for ln_out_packer. A second
//                instance with SHIFT=4 covers rounding and narrowing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ln_out_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ln_tdata = '0;
    logic        ln_tlast = 1'b0;
    logic        ln_tvalid = 1'b0;
    logic        ln_tready;
    logic [31:0] out_tdata;
    logic [3:0]  out_tkeep;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic [23:0] dim1 = 24'd1;
    logic [23:0] dim2 = 24'd8;
    logic        tlast_err;

    logic [31:0] a_tdata = '0;
    logic        a_tlast = 1'b0;
    logic        a_tvalid = 1'b0;
    logic        a_tready;
    logic [31:0] a_out_tdata;
    logic [3:0]  a_out_tkeep;
    logic        a_out_tlast;
    logic        a_out_tvalid;
    logic        a_tlast_err;
    logic [23:0] a_dim1 = 24'd1;
    logic [23:0] a_dim2 = 24'd4;

    int checks = 0;
    int passes = 0;
    int otr_pct = 100;
    int stall_err = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    logic        q_last[$];
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;

    ln_out_packer #(.D_W_ACC(32), .D_W(8), .X_W(32), .SHIFT(0), .MATRIXSIZE_W(24)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ln_tdata(ln_tdata), .ln_tlast(ln_tlast), .ln_tvalid(ln_tvalid), .ln_tready(ln_tready),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .DIM1(dim1), .DIM2(dim2), .tlast_err(tlast_err)
    );

    ln_out_packer #(.D_W_ACC(32), .D_W(8), .X_W(32), .SHIFT(4), .MATRIXSIZE_W(24)) u_dut_shift (
        .clk(clk), .rst_n(rst_n),
        .ln_tdata(a_tdata), .ln_tlast(a_tlast), .ln_tvalid(a_tvalid), .ln_tready(a_tready),
        .out_tdata(a_out_tdata), .out_tkeep(a_out_tkeep), .out_tlast(a_out_tlast),
        .out_tvalid(a_out_tvalid), .out_tready(out_tready),
        .DIM1(a_dim1), .DIM2(a_dim2), .tlast_err(a_tlast_err)
    );

    always #5 clk = ~clk;

    // Sink ready pattern, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1 out_tready = ($urandom_range(0, 99) < otr_pct);
        end
    end

    // Output monitor: collect handshaken words, watch stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (out_tvalid !== 1'b1 || out_tdata !== stall_data)) stall_err++;
            if (out_tvalid && !out_tready && ln_tready) stall_err++;
            if (out_tvalid && out_tready) begin
                q_data.push_back(out_tdata);
                q_keep.push_back(out_tkeep);
                q_last.push_back(out_tlast);
            end
            stall_prev = out_tvalid && !out_tready;
            stall_data = out_tdata;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [31:0] d, input logic l, input int pv);
        bit done = 1'b0;
        int g = 0;
        while (!done && g < 5000) begin
            @(posedge clk);
            #1;
            ln_tdata  = d;
            ln_tlast  = l;
            ln_tvalid = ($urandom_range(0, 99) < pv);
            @(negedge clk);
            done = ln_tvalid && ln_tready;
            g++;
        end
        if (!done) chk("send_timeout", done, 1'b1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        ln_tvalid = 1'b0;
        ln_tlast  = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int g = 0;
        while (q_data.size() < n && g < budget) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk(tag, q_data.size(), n);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        chk({tag, "_avail"}, q_data.size() != 0, 1'b1);
        if (q_data.size() != 0) begin
            chk({tag, "_data"}, q_data.pop_front(), d);
            chk({tag, "_keep"}, q_keep.pop_front(), k);
            chk({tag, "_last"}, q_last.pop_front(), l);
        end
    endtask

    initial begin
        logic [31:0] rv[4];
        logic [31:0] exp_round;
        logic [31:0] acc;
        logic [31:0] bp_exp[$];
        logic [7:0]  b;
        int mism;
        int lasts;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_tvalid", out_tvalid, 1'b0);
        chk("rst_out_tdata", out_tdata, 32'h0);
        chk("rst_out_tkeep", out_tkeep, 4'h0);
        chk("rst_out_tlast", out_tlast, 1'b0);
        chk("rst_tlast_err", tlast_err, 1'b0);
        chk("rst_ln_tready", ln_tready, 1'b1);

        // ---------------- basic packing ----------------
        dim1 = 24'd1; dim2 = 24'd8;
        for (int i = 1; i <= 8; i++) send(32'(i), i == 8, 100);
        idle();
        wait_words("basic_count", 2, 50);
        chk_word("basic_w0", 32'h04030201, 4'hF, 1'b0);
        chk_word("basic_w1", 32'h08070605, 4'hF, 1'b1);
        chk("basic_err", tlast_err, 1'b0);

        // ---------------- partial row flush ----------------
        dim1 = 24'd2; dim2 = 24'd6;
        for (int i = 0; i < 12; i++) send(32'h10, i == 11, 100);
        idle();
        wait_words("flush_count", 4, 50);
        chk_word("flush_w0", 32'h10101010, 4'hF, 1'b0);
        chk_word("flush_w1", 32'h00001010, 4'h3, 1'b0);
        chk_word("flush_w2", 32'h10101010, 4'hF, 1'b0);
        chk_word("flush_w3", 32'h00001010, 4'h3, 1'b1);
        chk("flush_err", tlast_err, 1'b0);

        // ---------------- rounding / narrowing (SHIFT=4) ----------------
        // 24->2, -24->-1, 5000->313 (0x139), -5000->-312 (0x..EC8)
        rv[0] = 32'h00000018;
        rv[1] = 32'hFFFFFFE8;
        rv[2] = 32'h00001388;
        rv[3] = 32'hFFFFEC78;
`ifdef LN_OUT_SAT_EN
        exp_round = 32'h807FFF02;
`else
        exp_round = 32'hC839FF02;
`endif
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            a_tdata  = rv[i];
            a_tvalid = 1'b1;
            a_tlast  = (i == 3);
        end
        @(posedge clk);
        #1 a_tvalid = 1'b0;
        a_tlast = 1'b0;
        @(negedge clk);
        chk("round_valid", a_out_tvalid, 1'b1);
        chk("round_data", a_out_tdata, exp_round);
        chk("round_keep", a_out_tkeep, 4'hF);
        chk("round_last", a_out_tlast, 1'b1);
        chk("round_err", a_tlast_err, 1'b0);

        // ---------------- tlast error ----------------
        dim1 = 24'd1; dim2 = 24'd8;
        for (int i = 1; i <= 3; i++) send(32'h20 + 32'(i), 1'b0, 100);
        send(32'h24, 1'b1, 100);
        chk("terr_before", tlast_err, 1'b0);
        send(32'h25, 1'b0, 100);
        chk("terr_next_cycle", tlast_err, 1'b1);
        for (int i = 6; i <= 8; i++) send(32'h20 + 32'(i), 1'b0, 100);
        idle();
        wait_words("terr_count", 2, 50);
        chk_word("terr_w0", 32'h24232221, 4'hF, 1'b0);
        chk_word("terr_w1", 32'h28272625, 4'hF, 1'b1);
        chk("terr_sticky", tlast_err, 1'b1);

        // ---------------- mid-frame reset ----------------
        for (int i = 1; i <= 3; i++) send(32'h30 + 32'(i), 1'b0, 100);
        @(posedge clk);
        #1 ln_tvalid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mrst_no_word", q_data.size(), 0);
        chk("mrst_err_clear", tlast_err, 1'b0);
        chk("mrst_valid", out_tvalid, 1'b0);
        for (int i = 1; i <= 8; i++) send(32'h10 + 32'(i), i == 8, 100);
        idle();
        wait_words("mrst_count", 2, 50);
        chk_word("mrst_w0", 32'h14131211, 4'hF, 1'b0);
        chk_word("mrst_w1", 32'h18171615, 4'hF, 1'b1);

        // ---------------- back-pressure ----------------
        dim1 = 24'd4; dim2 = 24'd768;
        otr_pct = 50;
        stall_err = 0;
        acc = '0;
        for (int n = 0; n < 3072; n++) begin
            b = 8'($urandom_range(0, 255));
            acc[(n % 4) * 8 +: 8] = b;
            if (n % 4 == 3) bp_exp.push_back(acc);
            send({{24{b[7]}}, b}, n == 3071, 50);
        end
        idle();
        otr_pct = 100;
        wait_words("bp_count", 768, 4000);
        mism = 0;
        lasts = 0;
        for (int i = 0; i < q_data.size() && i < bp_exp.size(); i++) begin
            if (q_data[i] !== bp_exp[i] || q_keep[i] !== 4'hF || q_last[i] !== (i == 767)) mism++;
            if (q_last[i] === 1'b1) lasts++;
        end
        chk("bp_mismatches", mism, 0);
        chk("bp_tlast_count", lasts, 1);
        chk("bp_stall_stability", stall_err, 0);
        chk("bp_err", tlast_err, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
